// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state controller, instruction register and
// IDCODE/BYPASS/boundary-scan/user data registers with a falling-edge TDO.
module jtag_tap_param #(
   parameter int                    IR_WIDTH     = 4,
   parameter int                    BSR_LEN      = 10,
   parameter int                    USER_WIDTH   = 8,
   parameter logic [31:0]           IDCODE_VALUE = 32'h1234_5677,
   parameter logic [USER_WIDTH-1:0] USER_INIT    = '0,
   parameter logic [IR_WIDTH-1:0]   OP_IDCODE    = IR_WIDTH'(7),
   parameter logic [IR_WIDTH-1:0]   OP_SAMPLE    = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0]   OP_EXTEST    = IR_WIDTH'(2),
   parameter logic [IR_WIDTH-1:0]   OP_INTEST    = IR_WIDTH'(3),
   parameter logic [IR_WIDTH-1:0]   OP_USERCODE  = IR_WIDTH'(8)
) (
   input  logic                  TCK,
   input  logic                  TRST,
   input  logic                  TMS,
   input  logic                  TDI,
   output logic                  TDO,
   output logic                  TDO_EN,
   output logic [3:0]            state,
   output logic                  TLR,
   input  logic [BSR_LEN-1:0]    BSR_CAPTURE,
   output logic [BSR_LEN-1:0]    BSR_UPDATE,
   output logic [USER_WIDTH-1:0] USER_REG,
   output logic                  SAMPLE_SELECT,
   output logic                  EXTEST_SELECT,
   output logic                  INTEST_SELECT,
   output logic                  USERCODE_SELECT,
   output logic                  BYPASS_SELECT
);

   typedef enum logic [3:0] {
      ST_TLR    = 4'hF, ST_RTI    = 4'hC,
      ST_SELDR  = 4'h7, ST_CAPDR  = 4'h6, ST_SHDR   = 4'h2, ST_EX1DR  = 4'h1,
      ST_PAUSDR = 4'h3, ST_EX2DR  = 4'h0, ST_UPDDR  = 4'h5,
      ST_SELIR  = 4'h4, ST_CAPIR  = 4'hE, ST_SHIR   = 4'hA, ST_EX1IR  = 4'h9,
      ST_PAUSIR = 4'hB, ST_EX2IR  = 4'h8, ST_UPDIR  = 4'hD
   } tap_state_e;

   tap_state_e            state_q, state_d;
   logic [IR_WIDTH-1:0]   ir_q, ir_d;
   logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
   logic [31:0]           id_sr_q, id_sr_d;
   logic                  byp_q, byp_d;
   logic [BSR_LEN-1:0]    bsr_sr_q, bsr_sr_d;
   logic [BSR_LEN-1:0]    bsr_upd_q, bsr_upd_d;
   logic [USER_WIDTH-1:0] user_sr_q, user_sr_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic                  tdo_q, tdo_en_q;

   logic sel_id, sel_smp, sel_ext, sel_int, sel_user, sel_bsr, sel_byp;
   logic dr_lsb;

   // Only the active IR is decoded, so the selects are stable during IR shifts.
   always_comb begin
      sel_id   = (ir_q == OP_IDCODE);
      sel_smp  = (ir_q == OP_SAMPLE);
      sel_ext  = (ir_q == OP_EXTEST);
      sel_int  = (ir_q == OP_INTEST);
      sel_user = (ir_q == OP_USERCODE);
      sel_bsr  = sel_smp | sel_ext | sel_int;
      sel_byp  = ~(sel_id | sel_bsr | sel_user);
   end

   always_comb begin
      dr_lsb = byp_q;
      if (sel_id)        dr_lsb = id_sr_q[0];
      else if (sel_bsr)  dr_lsb = bsr_sr_q[0];
      else if (sel_user) dr_lsb = user_sr_q[0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_TLR:    state_d = TMS ? ST_TLR   : ST_RTI;
         ST_RTI:    state_d = TMS ? ST_SELDR : ST_RTI;
         ST_SELDR:  state_d = TMS ? ST_SELIR : ST_CAPDR;
         ST_CAPDR:  state_d = TMS ? ST_EX1DR : ST_SHDR;
         ST_SHDR:   state_d = TMS ? ST_EX1DR : ST_SHDR;
         ST_EX1DR:  state_d = TMS ? ST_UPDDR : ST_PAUSDR;
         ST_PAUSDR: state_d = TMS ? ST_EX2DR : ST_PAUSDR;
         ST_EX2DR:  state_d = TMS ? ST_UPDDR : ST_SHDR;
         ST_UPDDR:  state_d = TMS ? ST_SELDR : ST_RTI;
         ST_SELIR:  state_d = TMS ? ST_TLR   : ST_CAPIR;
         ST_CAPIR:  state_d = TMS ? ST_EX1IR : ST_SHIR;
         ST_SHIR:   state_d = TMS ? ST_EX1IR : ST_SHIR;
         ST_EX1IR:  state_d = TMS ? ST_UPDIR : ST_PAUSIR;
         ST_PAUSIR: state_d = TMS ? ST_EX2IR : ST_PAUSIR;
         ST_EX2IR:  state_d = TMS ? ST_UPDIR : ST_SHIR;
         ST_UPDIR:  state_d = TMS ? ST_SELDR : ST_RTI;
         default:   state_d = ST_TLR;
      endcase
   end

   always_comb begin
      ir_d      = ir_q;
      ir_sr_d   = ir_sr_q;
      id_sr_d   = id_sr_q;
      byp_d     = byp_q;
      bsr_sr_d  = bsr_sr_q;
      bsr_upd_d = bsr_upd_q;
      user_sr_d = user_sr_q;
      user_d    = user_q;
      unique case (state_q)
         ST_TLR: begin
            ir_d      = OP_IDCODE;
            bsr_upd_d = '0;
         end
         ST_CAPIR: ir_sr_d = IR_WIDTH'(1);
         ST_SHIR: begin
            ir_sr_d               = ir_sr_q >> 1;
            ir_sr_d[IR_WIDTH-1]   = TDI;
         end
         ST_UPDIR: ir_d = ir_sr_q;
         ST_CAPDR: begin
            if (sel_id)        id_sr_d   = IDCODE_VALUE;
            else if (sel_bsr)  bsr_sr_d  = BSR_CAPTURE;
            else if (sel_user) user_sr_d = user_q;
            else               byp_d     = 1'b0;
         end
         // Shifts go through >>1 then an MSB insert so 1-bit registers stay legal.
         ST_SHDR: begin
            if (sel_id) begin
               id_sr_d     = id_sr_q >> 1;
               id_sr_d[31] = TDI;
            end else if (sel_bsr) begin
               bsr_sr_d              = bsr_sr_q >> 1;
               bsr_sr_d[BSR_LEN-1]   = TDI;
            end else if (sel_user) begin
               user_sr_d               = user_sr_q >> 1;
               user_sr_d[USER_WIDTH-1] = TDI;
            end else begin
               byp_d = TDI;
            end
         end
         ST_UPDDR: begin
            if (sel_bsr)       bsr_upd_d = bsr_sr_q;
            else if (sel_user) user_d    = user_sr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         state_q   <= ST_TLR;
         ir_q      <= OP_IDCODE;
         ir_sr_q   <= '0;
         id_sr_q   <= '0;
         byp_q     <= 1'b0;
         bsr_sr_q  <= '0;
         bsr_upd_q <= '0;
         user_sr_q <= '0;
         user_q    <= USER_INIT;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         ir_sr_q   <= ir_sr_d;
         id_sr_q   <= id_sr_d;
         byp_q     <= byp_d;
         bsr_sr_q  <= bsr_sr_d;
         bsr_upd_q <= bsr_upd_d;
         user_sr_q <= user_sr_d;
         user_q    <= user_d;
      end
   end

   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_en_q <= (state_q == ST_SHDR) || (state_q == ST_SHIR);
         if (state_q == ST_SHIR)      tdo_q <= ir_sr_q[0];
         else if (state_q == ST_SHDR) tdo_q <= dr_lsb;
         else                         tdo_q <= 1'b0;
      end
   end

   assign TDO             = tdo_q;
   assign TDO_EN          = tdo_en_q;
   assign state           = state_q;
   assign TLR             = (state_q == ST_TLR);
   assign BSR_UPDATE      = bsr_upd_q;
   assign USER_REG        = user_q;
   assign SAMPLE_SELECT   = sel_smp;
   assign EXTEST_SELECT   = sel_ext;
   assign INTEST_SELECT   = sel_int;
   assign USERCODE_SELECT = sel_user;
   assign BYPASS_SELECT   = sel_byp;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: IR/DR scans with hand-computed TDO streams.
module tb_jtag_tap_param;

   logic        TCK = 1'b0;
   logic        TRST, TMS, TDI;
   logic        TDO, TDO_EN, TLR;
   logic [3:0]  state;
   logic [9:0]  BSR_CAPTURE, BSR_UPDATE;
   logic [7:0]  USER_REG;
   logic        SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT, BYPASS_SELECT;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic        en_ok;
   logic [63:0] dout;
   logic [9:0]  vec10;

   jtag_tap_param #(
      .IR_WIDTH(4), .BSR_LEN(10), .USER_WIDTH(8)
   ) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
      .TDO(TDO), .TDO_EN(TDO_EN), .state(state), .TLR(TLR),
      .BSR_CAPTURE(BSR_CAPTURE), .BSR_UPDATE(BSR_UPDATE), .USER_REG(USER_REG),
      .SAMPLE_SELECT(SAMPLE_SELECT), .EXTEST_SELECT(EXTEST_SELECT),
      .INTEST_SELECT(INTEST_SELECT), .USERCODE_SELECT(USERCODE_SELECT),
      .BYPASS_SELECT(BYPASS_SELECT)
   );

   always #10 TCK = ~TCK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive after a falling edge, then settle just past the next falling edge.
   task automatic tick(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask

   task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] q);
      q     = '0;
      en_ok = 1'b1;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         q[i] = TDO;
         if (TDO_EN !== 1'b1) en_ok = 1'b0;
         tick(i == n - 1, din[i]);
      end
      if (TDO_EN !== 1'b0) en_ok = 1'b0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic scan_ir(input logic [3:0] din, output logic [63:0] q);
      q = '0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         q[i] = TDO;
         tick(i == 3, din[i]);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; BSR_CAPTURE = '0;
      @(negedge TCK); @(negedge TCK); #1;
      chk("rst_state", 64'(state), 64'hF);
      chk("rst_tlr", 64'(TLR), 64'd1);
      chk("rst_tdo", 64'({TDO, TDO_EN}), 64'd0);
      chk("rst_user", 64'(USER_REG), 64'd0);
      chk("rst_bsru", 64'(BSR_UPDATE), 64'd0);
      chk("rst_sel", 64'({SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT, BYPASS_SELECT}), 64'd0);
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      chk("rti", 64'(state), 64'hC);

      scan_dr(64'd0, 32, dout);
      chk("idcode", dout, 64'h1234_5677);
      chk("idcode_en", 64'(en_ok), 64'd1);

      scan_ir(4'hF, dout);
      chk("ir_capture", dout, 64'h1);
      chk("bypass_sel_f", 64'(BYPASS_SELECT), 64'd1);
      scan_dr(64'h0A5, 9, dout);
      chk("bypass_a5", dout, 64'h14A);

      scan_ir(4'h5, dout);
      chk("bypass_sel_5", 64'({BYPASS_SELECT, EXTEST_SELECT}), 64'b10);
      scan_dr(64'd1, 1, dout);
      chk("bypass_cap0", dout, 64'd0);

      scan_ir(4'h2, dout);
      chk("extest_sel", 64'({EXTEST_SELECT, BYPASS_SELECT}), 64'b10);
      BSR_CAPTURE = 10'h2A5;
      scan_dr(64'h3C3, 10, dout);
      chk("bsr_out", dout, 64'h2A5);
      chk("bsr_upd", 64'(BSR_UPDATE), 64'h3C3);

      vec10 = 10'h155;
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick(i == 9, vec10[i]);
      tick(1'b0, 1'b0);
      chk("pause_state", 64'(state), 64'h3);
      chk("pause_hold", 64'(BSR_UPDATE), 64'h3C3);
      tick(1'b1, 1'b0); tick(1'b1, 1'b0);
      chk("upd_state", 64'(state), 64'h5);
      chk("upd_hold", 64'(BSR_UPDATE), 64'h3C3);
      tick(1'b0, 1'b0);
      chk("upd_new", 64'(BSR_UPDATE), 64'h155);

      scan_ir(4'h8, dout);
      chk("user_sel", 64'(USERCODE_SELECT), 64'd1);
      scan_dr(64'h5A, 8, dout);
      chk("user_init_out", dout, 64'd0);
      chk("user_reg", 64'(USER_REG), 64'h5A);
      scan_dr(64'h5A, 8, dout);
      chk("user_recap", dout, 64'h5A);

      scan_ir(4'h2, dout);
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      chk("tlr5_state", 64'(state), 64'hF);
      chk("tlr5_user", 64'(USER_REG), 64'h5A);
      tick(1'b1, 1'b0);
      chk("tlr_bsru", 64'(BSR_UPDATE), 64'd0);
      chk("tlr_sel", 64'({EXTEST_SELECT, BYPASS_SELECT}), 64'd0);
      tick(1'b0, 1'b0);
      scan_dr(64'd0, 32, dout);
      chk("tlr_idcode", dout, 64'h1234_5677);

      scan_ir(4'h2, dout);
      scan_dr(64'h3C3, 10, dout);
      chk("pre_rst_bsru", 64'(BSR_UPDATE), 64'h3C3);
      scan_ir(4'h8, dout);
      tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
      tick(1'b0, 1'b1); tick(1'b0, 1'b1);
      chk("pre_rst_en", 64'(TDO_EN), 64'd1);
      #3 TRST = 1'b1;
      #1;
      chk("arst_state", 64'(state), 64'hF);
      chk("arst_tdo", 64'({TDO, TDO_EN}), 64'd0);
      chk("arst_user", 64'(USER_REG), 64'd0);
      chk("arst_bsru", 64'(BSR_UPDATE), 64'd0);
      chk("arst_sel", 64'(USERCODE_SELECT), 64'd0);
      @(negedge TCK); #1;
      TRST = 1'b0;
      tick(1'b0, 1'b0);
      scan_dr(64'd0, 32, dout);
      chk("arst_idcode", dout, 64'h1234_5677);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
